// File: rtl/decoder_pkg.sv
// Load/store size codes shared between the instruction decoder and the LSU.
package decoder_pkg;
  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;
endpackage

// File: rtl/lsu_pkg.sv
// LSU state encoding and the request legality check.
package lsu_pkg;
  import decoder_pkg::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // An access is legal when the size code exists, unsigned sizes are not stored,
  // and the address is naturally aligned for the access width.
  function automatic logic ldst_legal(input logic [2:0] size, input logic we,
                                      input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (size)
      LDST_B:  ok = 1'b1;
      LDST_BU: ok = !we;
      LDST_H:  ok = !off[0];
      LDST_HU: ok = !we && !off[0];
      LDST_W:  ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction
endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering: byte enables and write replication for requests,
// byte/half selection and extension for read responses.
module lsu_data_align
  import decoder_pkg::*;
(
  input  logic [2:0]  req_size,
  input  logic [1:0]  req_off,
  input  logic        req_we,
  input  logic [31:0] req_wd,
  output logic        req_legal,
  output logic [3:0]  req_be,
  output logic [31:0] req_wd_rep,
  input  logic [2:0]  rsp_size,
  input  logic [1:0]  rsp_off,
  input  logic [31:0] rsp_word,
  output logic [31:0] rsp_data
);
  import lsu_pkg::*;

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rsp_word[8*gi +: 8];
  end

  assign req_legal = ldst_legal(req_size, req_we, req_off);
  assign byte_sel  = lane[rsp_off];
  assign half_sel  = rsp_off[1] ? rsp_word[31:16] : rsp_word[15:0];

  always_comb begin
    req_be     = 4'b0000;
    req_wd_rep = req_wd;
    case (req_size)
      LDST_B, LDST_BU: begin
        req_be     = 4'b0001 << req_off;
        req_wd_rep = {4{req_wd[7:0]}};
      end
      LDST_H, LDST_HU: begin
        req_be     = 4'b0011 << {req_off[1], 1'b0};
        req_wd_rep = {2{req_wd[15:0]}};
      end
      LDST_W: begin
        req_be     = 4'b1111;
        req_wd_rep = req_wd;
      end
      default: begin
        req_be     = 4'b0000;
        req_wd_rep = req_wd;
      end
    endcase
  end

  always_comb begin
    rsp_data = rsp_word;
    case (rsp_size)
      LDST_B:  rsp_data = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: rsp_data = {24'h000000, byte_sel};
      LDST_H:  rsp_data = {{16{half_sel[15]}}, half_sel};
      LDST_HU: rsp_data = {16'h0000, half_sel};
      default: rsp_data = rsp_word;
    endcase
  end
endmodule

// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer: stalls the core while one handshaked memory
// access is in flight, and reports misaligned/illegal/timed-out accesses as faults.
module lsu_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        fault_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);
  import lsu_pkg::*;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             mem_req_reg;
  logic             mem_we_reg;
  logic [3:0]       mem_be_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      wd_reg;
  logic [1:0]       off_reg;
  logic [2:0]       size_reg;
  logic             fault_reg;
  logic [31:0]      rd_reg;

  logic             req_legal;
  logic [3:0]       req_be;
  logic [31:0]      req_wd_rep;
  logic [31:0]      rsp_data;

  lsu_data_align u_align (
    .req_size   (core_size_i),
    .req_off    (core_addr_i[1:0]),
    .req_we     (core_we_i),
    .req_wd     (core_wd_i),
    .req_legal  (req_legal),
    .req_be     (req_be),
    .req_wd_rep (req_wd_rep),
    .rsp_size   (size_reg),
    .rsp_off    (off_reg),
    .rsp_word   (mem_rd_i),
    .rsp_data   (rsp_data)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      mem_req_reg <= 1'b0;
      mem_we_reg  <= 1'b0;
      mem_be_reg  <= 4'b0000;
      addr_reg    <= 32'h0;
      wd_reg      <= 32'h0;
      off_reg     <= 2'b00;
      size_reg    <= 3'b000;
      fault_reg   <= 1'b0;
      rd_reg      <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          fault_reg <= 1'b0;
          if (core_req_i) begin
            if (req_legal) begin
              state_reg   <= BUSY;
              cnt_reg     <= '0;
              mem_req_reg <= 1'b1;
              mem_we_reg  <= core_we_i;
              mem_be_reg  <= req_be;
              addr_reg    <= {core_addr_i[31:2], 2'b00};
              wd_reg      <= req_wd_rep;
              off_reg     <= core_addr_i[1:0];
              size_reg    <= core_size_i;
            end else begin
              // Rejected requests never reach memory; they only report a fault.
              state_reg <= DONE;
              fault_reg <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (mem_ready_i) begin
            if (!mem_we_reg) begin
              rd_reg <= rsp_data;
            end
            state_reg   <= DONE;
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            mem_be_reg  <= 4'b0000;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg   <= DONE;
            fault_reg   <= 1'b1;
            rd_reg      <= 32'h0;
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            mem_be_reg  <= 4'b0000;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          fault_reg <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg   <= IDLE;
          fault_reg   <= 1'b0;
          mem_req_reg <= 1'b0;
          mem_we_reg  <= 1'b0;
          mem_be_reg  <= 4'b0000;
        end
      endcase
    end
  end

  assign core_stall_o = core_req_i && (state_reg != DONE);
  assign core_rd_o    = rd_reg;
  assign fault_o      = fault_reg;
  assign mem_req_o    = mem_req_reg;
  assign mem_we_o     = mem_we_reg;
  assign mem_be_o     = mem_be_reg;
  assign mem_addr_o   = addr_reg;
  assign mem_wd_o     = wd_reg;
endmodule

// File: tb/tb_lsu_sequencer.sv
// Scoreboard bench for lsu_sequencer: directed accesses push expected memory
// requests and core responses; two monitors pop and compare as they appear.
module tb_lsu_sequencer;
  import decoder_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        core_req_i = 1'b0;
  logic        core_we_i = 1'b0;
  logic [2:0]  core_size_i = 3'b000;
  logic [31:0] core_addr_i = 32'h0;
  logic [31:0] core_wd_i = 32'h0;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        fault_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i = 32'h0;
  logic        mem_ready_i = 1'b0;

  int checks = 0;
  int fails = 0;

  logic [32:0] rsp_q [$];   // {fault, rd}
  logic [68:0] mem_q [$];   // {we, be, addr, wd}

  lsu_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .fault_o      (fault_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Response monitor: a completed access is visible as request held with stall low.
  always @(negedge clk_i) begin
    logic [32:0] exp;
    if (rst_ni && core_req_i && !core_stall_o) begin
      if (rsp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL rsp_unexpected got fault=%b rd=%h want none", fault_o, core_rd_o);
      end else begin
        exp = rsp_q.pop_front();
        check32("rsp_fault", {31'h0, fault_o}, {31'h0, exp[32]});
        check32("rsp_rd", core_rd_o, exp[31:0]);
        $display("rsp  fault=%b rd=%h (exp fault=%b rd=%h)", fault_o, core_rd_o, exp[32], exp[31:0]);
      end
    end
  end

  // Memory monitor: compare request fields on the first cycle of each mem_req_o burst.
  logic prev_req = 1'b0;
  always @(negedge clk_i) begin
    logic [68:0] exp;
    if (mem_req_o && !prev_req) begin
      if (mem_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL mem_unexpected got addr=%h be=%b want none", mem_addr_o, mem_be_o);
      end else begin
        exp = mem_q.pop_front();
        check32("mem_we", {31'h0, mem_we_o}, {31'h0, exp[68]});
        check32("mem_be", {28'h0, mem_be_o}, {28'h0, exp[67:64]});
        check32("mem_addr", mem_addr_o, exp[63:32]);
        check32("mem_wd", mem_wd_o, exp[31:0]);
        $display("mem  we=%b be=%b addr=%h wd=%h", mem_we_o, mem_be_o, mem_addr_o, mem_wd_o);
      end
    end
    prev_req = mem_req_o;
  end

  task automatic run_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdata, input int ready_at,
                            input logic exp_fault, input logic [31:0] exp_rd, input logic exp_mem,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd, input int exp_busy);
    int stall_cyc;
    int busy;
    bit done;
    rsp_q.push_back({exp_fault, exp_rd});
    if (exp_mem) mem_q.push_back({we, exp_be, addr[31:2], 2'b00, exp_wd});
    @(posedge clk_i); #1;
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    mem_rd_i    = rdata;
    mem_ready_i = 1'b0;
    stall_cyc = 1;
    busy = 0;
    done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_i); #1;
      if (!core_stall_o) begin
        done = 1'b1;
        break;
      end
      stall_cyc++;
      if (mem_req_o) begin
        if (busy == ready_at) mem_ready_i = 1'b1;
        busy++;
      end
    end
    mem_ready_i = 1'b0;
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL access_timeout got stalled 40 cycles want completion");
    end
    check32("stall_cycles", stall_cyc, 1 + exp_busy);
    check32("busy_cycles", busy, exp_busy);
    @(posedge clk_i); #1;
    core_req_i = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check32("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
    check32("rst_mem_we", {31'h0, mem_we_o}, 32'h0);
    check32("rst_mem_be", {28'h0, mem_be_o}, 32'h0);
    check32("rst_fault", {31'h0, fault_o}, 32'h0);
    check32("rst_rd", core_rd_o, 32'h0);
    check32("rst_stall", {31'h0, core_stall_o}, 32'h0);
    rst_ni = 1'b1;

    //          we    size     addr          wd            rdata         rdy  fault rd            mem   be       wd            busy
    run_access(1'b0, LDST_W,  32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF, 1'b1, 4'b1111, 32'h0,        1);
    run_access(1'b0, LDST_B,  32'h0000_0103, 32'h0,        32'h80FF_0000, 1, 1'b0, 32'hFFFF_FF80, 1'b1, 4'b1000, 32'h0,        2);
    run_access(1'b0, LDST_BU, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0, 1'b0, 32'h0000_0080, 1'b1, 4'b1000, 32'h0,        1);
    run_access(1'b1, LDST_H,  32'h0000_0202, 32'h1234_ABCD, 32'h0,       0, 1'b0, 32'h0000_0080, 1'b1, 4'b1100, 32'hABCD_ABCD, 1);
    run_access(1'b0, LDST_W,  32'h0000_0101, 32'h0,        32'h1111_1111, 0, 1'b1, 32'h0000_0080, 1'b0, 4'b0000, 32'h0,        0);
    run_access(1'b1, LDST_B,  32'h0000_0301, 32'h0000_0055, 32'h0,      -1, 1'b1, 32'h0000_0000, 1'b1, 4'b0010, 32'h5555_5555, 4);
    run_access(1'b0, LDST_H,  32'h0000_0102, 32'h0,        32'h8001_1234, 0, 1'b0, 32'hFFFF_8001, 1'b1, 4'b1100, 32'h0,        1);
    run_access(1'b0, LDST_HU, 32'h0000_0102, 32'h0,        32'h8001_1234, 0, 1'b0, 32'h0000_8001, 1'b1, 4'b1100, 32'h0,        1);
    run_access(1'b0, LDST_W,  32'h0000_0104, 32'h0,        32'h1234_5678, 0, 1'b0, 32'h1234_5678, 1'b1, 4'b1111, 32'h0,        1);
    run_access(1'b0, 3'b011,  32'h0000_0000, 32'h0,        32'h0,         0, 1'b1, 32'h1234_5678, 1'b0, 4'b0000, 32'h0,        0);
    run_access(1'b1, LDST_BU, 32'h0000_0000, 32'h0000_00AA, 32'h0,       0, 1'b1, 32'h1234_5678, 1'b0, 4'b0000, 32'h0,        0);
    run_access(1'b0, LDST_H,  32'h0000_0101, 32'h0,        32'h0,         0, 1'b1, 32'h1234_5678, 1'b0, 4'b0000, 32'h0,        0);
    run_access(1'b1, LDST_W,  32'h0000_0010, 32'hCAFE_F00D, 32'h0,       2, 1'b0, 32'h1234_5678, 1'b1, 4'b1111, 32'hCAFE_F00D, 3);
    run_access(1'b0, LDST_B,  32'h0000_0100, 32'h0,        32'h0000_007F, 0, 1'b0, 32'h0000_007F, 1'b1, 4'b0001, 32'h0,        1);

    // Reset while BUSY: request drops at the next edge, a late ready is ignored.
    mem_q.push_back({1'b0, 4'b1111, 32'h0000_0200, 32'h0});
    @(posedge clk_i); #1;
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = LDST_W;
    core_addr_i = 32'h0000_0200;
    core_wd_i   = 32'h0;
    mem_rd_i    = 32'hFFFF_FFFF;
    @(posedge clk_i); #1;
    check32("busy_mem_req", {31'h0, mem_req_o}, 32'h1);
    rst_ni = 1'b0;
    core_req_i = 1'b0;
    @(posedge clk_i); #1;
    check32("rst_busy_mem_req", {31'h0, mem_req_o}, 32'h0);
    check32("rst_busy_rd", core_rd_o, 32'h0);
    rst_ni = 1'b1;
    mem_ready_i = 1'b1;
    repeat (3) begin
      @(posedge clk_i); #1;
      check32("late_ready_mem_req", {31'h0, mem_req_o}, 32'h0);
      check32("late_ready_rd", core_rd_o, 32'h0);
      check32("late_ready_fault", {31'h0, fault_o}, 32'h0);
    end
    mem_ready_i = 1'b0;

    run_access(1'b0, LDST_W,  32'h0000_0008, 32'h0,        32'hA5A5_A5A5, 0, 1'b0, 32'hA5A5_A5A5, 1'b1, 4'b1111, 32'h0,        1);

    repeat (2) @(posedge clk_i);
    #1;
    check32("rsp_q_empty", rsp_q.size(), 0);
    check32("mem_q_empty", mem_q.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
